// File: rtl/div_512_seq.sv
// Sequential radix-2 restoring divider: DW-bit dividend / VW-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake.
module div_512_seq #(
  parameter int DW = 512,
  parameter int VW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend_in,
  input  logic [VW-1:0] divisor_in,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic           w_accept;

  logic [DW-1:0]  r_q;
  logic [VW-1:0]  r_d;
  logic [VW-1:0]  r_rem;
  logic [CW-1:0]  r_cnt;
  logic [DW-1:0]  r_quotient;
  logic [VW-1:0]  r_remainder;
  logic           r_divByZero;

  logic [VW:0]    w_trial;
  logic           w_ge;
  logic [VW-1:0]  w_sub;
  logic [VW-1:0]  w_remNext;
  logic [DW-1:0]  w_qNext;

  // The trial value carries the extra bit, so the stored remainder
  // (always < divisor) fits in VW bits.
  assign w_trial   = {r_rem, r_q[DW-1]};
  assign w_ge      = (w_trial >= {1'b0, r_d});
  assign w_sub     = w_trial[VW-1:0] - r_d;
  assign w_remNext = w_ge ? w_sub : w_trial[VW-1:0];
  assign w_qNext   = {r_q[DW-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = (divisor_in == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = (divisor_in == '0) ? S_DONE : S_RUN;
        end else begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_d         <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
    end else if (w_accept) begin
      r_q         <= dividend_in;
      r_d         <= divisor_in;
      r_rem       <= '0;
      r_cnt       <= CW'(DW - 1);
      r_divByZero <= 1'b0;
      if (divisor_in == '0) begin
        r_quotient  <= '1;
        r_remainder <= '0;
        r_divByZero <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_q   <= w_qNext;
      r_rem <= w_remNext;
      // Last iteration publishes the freshly shifted values directly.
      if (r_cnt == '0) begin
        r_quotient  <= w_qNext;
        r_remainder <= w_remNext;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign div_by_zero = r_divByZero;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;

endmodule

// File: tb/tb_div_512_seq.sv
// Self-checking bench for div_512_seq: directed corner cases plus randomized
// operands compared against plain SystemVerilog / and % arithmetic.
module tb_div_512_seq;

  localparam int DW    = 512;
  localparam int VW    = 128;
  localparam int LIMIT = 2000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividendIn;
  logic [VW-1:0] divisorIn;
  logic          busy;
  logic          done;
  logic          divByZero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int errorCount = 0;
  int checkCount = 0;
  bit overlapSeen = 0;

  div_512_seq #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend_in (dividendIn),
    .divisor_in  (divisorIn),
    .busy        (busy),
    .done        (done),
    .div_by_zero (divByZero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && busy && done) overlapSeen = 1;
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] rand512();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Launch one division: start is high for exactly one rising edge.
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [VW-1:0] b);
    @(negedge clk);
    dividendIn = a;
    divisorIn  = b;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in cycle 1 after an accept; returns the cycle number done appeared in.
  task automatic waitDone(input int injectAt, output int lat, output int busyCycles,
                          output bit changed);
    logic [DW-1:0] q0;
    logic [VW-1:0] r0;
    logic          d0;
    q0 = quotient;
    r0 = remainder;
    d0 = divByZero;
    lat = 1;
    busyCycles = 0;
    changed = 0;
    while (!done && lat < LIMIT) begin
      if (busy) busyCycles++;
      if (quotient !== q0 || remainder !== r0 || divByZero !== d0) changed = 1;
      start = (lat == injectAt);
      if (lat == injectAt) begin
        dividendIn = rand512();
        divisorIn  = 128'd3;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) checkOutput("timeout", DW'(done), 1);
  endtask

  task automatic checkResult(input string tag, input int lat, input int busyCycles,
                             input bit changed, input logic [VW-1:0] b,
                             input logic [DW-1:0] expQ, input logic [VW-1:0] expR,
                             input logic expDbz);
    checkOutput({tag, ".lat"}, DW'(lat), (b == 0) ? 1 : DW + 1);
    checkOutput({tag, ".busy"}, DW'(busyCycles), (b == 0) ? 0 : DW);
    checkOutput({tag, ".stable"}, DW'(changed), 0);
    checkOutput({tag, ".q"}, quotient, expQ);
    checkOutput({tag, ".r"}, DW'(remainder), DW'(expR));
    checkOutput({tag, ".dbz"}, DW'(divByZero), DW'(expDbz));
  endtask

  task automatic runCheck(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input logic [DW-1:0] expQ, input logic [VW-1:0] expR,
                          input logic expDbz);
    int lat, busyCycles;
    bit changed;
    applyStimulus(a, b);
    if (b != 0) checkOutput({tag, ".dbzClr"}, DW'(divByZero), 0);
    waitDone(0, lat, busyCycles, changed);
    checkResult(tag, lat, busyCycles, changed, b, expQ, expR, expDbz);
  endtask

  task automatic runModel(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b);
    if (b == 0) runCheck(tag, a, b, '1, '0, 1'b1);
    else runCheck(tag, a, b, a / DW'(b), VW'(a % DW'(b)), 1'b0);
  endtask

  initial begin
    int lat, busyCycles;
    bit changed;
    bit doneSeen;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW+VW-1:0] recon;

    rst_n = 1'b0;
    start = 1'b0;
    dividendIn = '0;
    divisorIn = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst.busy", DW'(busy), 0);
    checkOutput("rst.done", DW'(done), 0);
    checkOutput("rst.dbz", DW'(divByZero), 0);
    checkOutput("rst.q", quotient, 0);
    checkOutput("rst.r", DW'(remainder), 0);

    runCheck("basic", 100, 7, 14, 2, 1'b0);
    runCheck("onesDiv1", '1, 1, '1, 0, 1'b0);
    runModel("onesDivOnes", '1, '1);
    recon = (DW+VW)'(quotient) * (DW+VW)'(128'hffffffff_ffffffff_ffffffff_ffffffff)
            + (DW+VW)'(remainder);
    checkOutput("onesDivOnes.recon", recon[DW-1:0], '1);
    checkOutput("onesDivOnes.reconHi", DW'(recon[DW+VW-1:DW]), 0);
    checkOutput("onesDivOnes.remLt", DW'(remainder < 128'hffffffff_ffffffff_ffffffff_ffffffff), 1);
    runCheck("small", 5, 9, 0, 5, 1'b0);
    runCheck("dbz", 123, 0, '1, 0, 1'b1);
    runCheck("afterDbz", 1000, 10, 100, 0, 1'b0);

    // Start pulse mid-run must be ignored.
    applyStimulus(1000, 7);
    waitDone(200, lat, busyCycles, changed);
    checkResult("ignoreStart", lat, busyCycles, changed, 7, 142, 6, 1'b0);

    // Back-to-back: start held through DONE.
    applyStimulus(12345, 100);
    waitDone(0, lat, busyCycles, changed);
    checkResult("b2b1", lat, busyCycles, changed, 100, 123, 45, 1'b0);
    dividendIn = 999;
    divisorIn  = 4;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b.doneLow", DW'(done), 0);
    checkOutput("b2b.busyHigh", DW'(busy), 1);
    waitDone(0, lat, busyCycles, changed);
    checkResult("b2b2", lat, busyCycles, changed, 4, 249, 3, 1'b0);

    // Reset in cycle 300 of a run.
    applyStimulus(rand512(), 5);
    repeat (299) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midRst.busy", DW'(busy), 0);
    checkOutput("midRst.done", DW'(done), 0);
    checkOutput("midRst.dbz", DW'(divByZero), 0);
    checkOutput("midRst.q", quotient, 0);
    checkOutput("midRst.r", DW'(remainder), 0);
    doneSeen = 0;
    repeat (600) begin
      @(negedge clk);
      if (done || busy) doneSeen = 1;
    end
    checkOutput("midRst.noDone", DW'(doneSeen), 0);
    runCheck("postRst", 77777, 11, 7070, 7, 1'b0);

    // Multiply-accumulate round trip: (A*B)/B gives back A exactly.
    for (int i = 0; i < 40; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      b = b >> $urandom_range(0, 127);
      if (b == 0) b = 1;
      a = rand512();
      a = DW'(a[VW-1:0]);
      runCheck("mac", DW'(a) * DW'(b), b, a, 0, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      a = rand512() >> $urandom_range(0, DW - 1);
      b = {$urandom, $urandom, $urandom, $urandom};
      b = b >> $urandom_range(0, 127);
      if ($urandom_range(0, 15) == 0) b = 0;
      runModel("rand", a, b);
    end

    checkOutput("busyDoneOverlap", DW'(overlapSeen), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
